// File: rtl/rewire_bridge_pkg.sv
// rewire_bridge_pkg
// Shared types and constants for the rewire stream bridge.
//   rwb_state_t         : bridge FSM state (IDLE / SHIFT / HOLD)
//   RWB_DEFAULT_W       : default host word width
//   rwb_shift_cycles(w) : number of device steps per word
// Optional feature macro: RWB_PARITY_EN (adds one parity step per word).
package rewire_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rwb_state_t;

    localparam int RWB_DEFAULT_W = 8;

    // Device steps spent in SHIFT for one word of width w.
    function automatic int rwb_shift_cycles(input int w);
`ifdef RWB_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/rewire_bridge_shreg.sv
// rewire_bridge_shreg
// W-bit shift register: parallel load, shift toward the LSB, serial input at
// the MSB, serial output taken from q_o[0]. Load wins over shift.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (clears to 0)
//   load_i       : load load_data_i on the next edge
//   load_data_i  : parallel load value
//   shift_i      : shift one place toward the LSB on the next edge
//   ser_i        : bit entering at the MSB on a shift
//   q_o          : register contents
module rewire_bridge_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] shift_d;

    // A one-bit register simply takes the serial input on a shift.
    generate
        if (W == 1) begin : g_w1
            assign shift_d = ser_i;
        end else begin : g_wn
            assign shift_d = {ser_i, q_q[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= load_data_i;
        end else if (shift_i) begin
            q_q <= shift_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/rewire_stream_bridge.sv
// rewire_stream_bridge
// Host-side bridge to a single-bit stream device. A host word accepted on the
// in_* handshake is shifted LSB-first onto dev_in0 while dev_step enables the
// device; the device's dev_out0 bits are collected into out_data (bit k of the
// result is the response to bit k of the word). The result is held on the
// out_* handshake, and the device is not stepped while the host stalls.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. valid stays high until that edge; data is stable while valid.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : host word handshake, in_data word
//   out_valid/out_ready   : result handshake, out_data word
//   dev_step              : device clock enable (high for each SHIFT cycle)
//   dev_in0 / dev_out0    : serial bit to / from the device (dev_out0 is Mealy)
//   busy                  : high outside IDLE
//   out_par_err           : (RWB_PARITY_EN only) parity mismatch, valid with out_valid
//   dbg_state             : current FSM state
// Optional feature macro: RWB_PARITY_EN.
module rewire_stream_bridge
    import rewire_bridge_pkg::*;
#(
    parameter int W     = RWB_DEFAULT_W,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         dev_step,
    output logic         dev_in0,
    input  logic         dev_out0,
    output logic         busy,
`ifdef RWB_PARITY_EN
    output logic         out_par_err,
`endif
    output rwb_state_t   dbg_state
);

    localparam int             N_STEPS = rwb_shift_cycles(W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_STEPS - 1);

    rwb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             dev_step_q;
    logic             busy_q;

    logic             accept;
    logic             tx_shift_en;
    logic             rx_shift_en;
    logic [W-1:0]     tx_q;
    logic [W-1:0]     rx_q;

    assign accept      = (state_q == IDLE) && in_valid;
    // dev_step_q is high exactly in SHIFT, so it doubles as the shift enable.
    assign tx_shift_en = dev_step_q;
    assign cnt_d       = cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // FSM with registered handshake / step outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dev_step_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= SHIFT;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        dev_step_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST) begin
                        state_q     <= HOLD;
                        dev_step_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    dev_step_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Parity step (optional) and serial bit selection
    // ------------------------------------------------------------------
`ifdef RWB_PARITY_EN
    logic par_step;
    logic par_q;
    logic par_err_q;

    // The extra step after the W data bits carries the word's parity.
    assign par_step    = dev_step_q && (cnt_q == CNT_W'(W));
    // rx_q must keep the W data responses, so it does not move on the parity step.
    assign rx_shift_en = dev_step_q && !par_step;
    assign dev_in0     = dev_step_q && (par_step ? par_q : tx_q[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else if (accept) begin
            par_q     <= ^in_data;
            par_err_q <= 1'b0;
        end else if (par_step) begin
            par_err_q <= dev_out0 ^ (^rx_q);
        end
    end

    assign out_par_err = par_err_q;
`else
    assign rx_shift_en = dev_step_q;
    assign dev_in0     = dev_step_q && tx_q[0];
`endif

    // ------------------------------------------------------------------
    // Serialiser / deserialiser
    // ------------------------------------------------------------------
    rewire_bridge_shreg #(.W(W)) u_tx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .load_data_i (in_data),
        .shift_i     (tx_shift_en),
        .ser_i       (1'b0),
        .q_o         (tx_q)
    );

    // Responses enter at the MSB, so after W shifts bit k holds the k-th response.
    rewire_bridge_shreg #(.W(W)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .load_data_i ('0),
        .shift_i     (rx_shift_en),
        .ser_i       (dev_out0),
        .q_o         (rx_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = rx_q;
    assign dev_step  = dev_step_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rewire_stream_bridge.sv
// Testbench for rewire_stream_bridge (W=8). Build with +define+RWB_PARITY_EN
// for the parity variant.
module tb_rewire_stream_bridge;
    import rewire_bridge_pkg::*;

    localparam int W = 8;
`ifdef RWB_PARITY_EN
    localparam int NS = W + 1;
`else
    localparam int NS = W;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         dev_step;
    logic         dev_in0;
    logic         dev_out0;
    logic         busy;
    logic         out_par_err;
    rwb_state_t   dbg_state;

    rewire_stream_bridge #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .dev_step    (dev_step),
        .dev_in0     (dev_in0),
        .dev_out0    (dev_out0),
        .busy        (busy),
`ifdef RWB_PARITY_EN
        .out_par_err (out_par_err),
`endif
        .dbg_state   (dbg_state)
    );

`ifndef RWB_PARITY_EN
    assign out_par_err = 1'b0;
`endif

    // ---------------- device model ----------------
    // mode 0: loopback, 1: inverter, 2: toggle-state device
    int   mode;
    logic par_kill;
    logic [1:0] dev_s;
    logic model_bit;

    always_comb begin
        model_bit = dev_in0;
        case (mode)
            1:       model_bit = ~dev_in0;
            2:       model_bit = dev_in0 ^ dev_s[0];
            default: model_bit = dev_in0;
        endcase
        dev_out0 = par_kill ? 1'b0 : model_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_s <= 2'b11;
        end else if (dev_step && mode == 2) begin
            dev_s <= {dev_s[0], dev_s[1] ^ dev_in0};
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         err_q[$];
    logic [1:0]   ref_s;
    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result word and parity-error flag for word w under the current mode.
    function automatic void model(input logic [W-1:0] w, input bit kill,
                                  output logic [W-1:0] ew, output logic eerr);
        logic b;
        logic p;
        ew = '0;
        for (int k = 0; k < W; k++) begin
            case (mode)
                1: b = ~w[k];
                2: begin
                    b = w[k] ^ ref_s[0];
                    ref_s = {ref_s[0], ref_s[1] ^ w[k]};
                end
                default: b = w[k];
            endcase
            ew[k] = b;
        end
        eerr = 1'b0;
`ifdef RWB_PARITY_EN
        p = ^w;
        case (mode)
            1: b = ~p;
            2: begin
                b = p ^ ref_s[0];
                ref_s = {ref_s[0], ref_s[1] ^ p};
            end
            default: b = p;
        endcase
        if (kill) b = 1'b0;
        eerr = b ^ (^ew);
`else
        p = kill;
        b = p;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge in IDLE; returns at the negedge of the first HOLD cycle.
    task automatic send(input logic [W-1:0] w, input bit kill);
        logic [W-1:0] ew;
        logic         eerr;
        logic [W-1:0] bits;
        logic         pbit;
        int steps;
        int lat;
        model(w, kill, ew, eerr);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        exp_q.push_back(ew);
        err_q.push_back(eerr);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom_range(0, 255));
        bits  = '0;
        pbit  = 1'b0;
        steps = 0;
        lat   = 0;
        while (lat < 40) begin
            @(negedge clk);
            par_kill = 1'b0;
            lat++;
            if (out_valid) break;
            if (dev_step) begin
                if (steps < W) bits[steps] = dev_in0;
                else begin
                    pbit = dev_in0;
                    if (kill) par_kill = 1'b1;
                end
                steps++;
            end
            check("in_ready_busy", in_ready, 0);
        end
        check("latency", lat, NS + 1);
        check("step_count", steps, NS);
        check("dev_in0_seq", bits, w);
`ifdef RWB_PARITY_EN
        check("parity_bit", pbit, ^w);
`endif
    endtask

    // Called at the negedge of the first HOLD cycle; returns at a negedge in IDLE.
    task automatic recv(input int stall, input bit poke);
        logic [W-1:0] e;
        logic         ee;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e  = exp_q.pop_front();
        ee = err_q.pop_front();
        check("out_valid", out_valid, 1);
        check("hold_state", dbg_state, HOLD);
        check("hold_dev_in0", dev_in0, 0);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            if (poke) in_valid = (i % 2 == 0);
            in_data = W'($urandom_range(0, 255));
            @(negedge clk);
            check("stall_data", out_data, e);
            check("stall_step", dev_step, 0);
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        check("out_data", out_data, e);
`ifdef RWB_PARITY_EN
        check("out_par_err", out_par_err, ee);
`else
        check("no_par_err", out_par_err, ee);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_step", dev_step, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        total     = 0;
        bad       = 0;
        mode      = 0;
        par_kill  = 1'b0;
        ref_s     = 2'b11;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_dev_step", dev_step, 0);
        check("rst_dev_in0", dev_in0, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_par_err", out_par_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Loopback
        mode = 0;
        send(8'hA5, 1'b0);
        recv(0, 1'b0);

        // Inverter; out_ready high during SHIFT must not matter
        mode = 1;
        send(8'h0F, 1'b0);
        recv(0, 1'b0);
        out_ready = 1'b1;
        send(8'h00, 1'b0);
        recv(0, 1'b0);

        // Backpressure with in_valid poked during the stall
        mode = 0;
        send(8'h5A, 1'b0);
        recv(20, 1'b1);

        // Reset in the middle of SHIFT
        check("mid_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_shifting", dev_step, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_step", dev_step, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h3C, 1'b0);
        recv(0, 1'b0);

        // Toggle-state device, four words back to back
        mode  = 2;
        ref_s = 2'b11;
        for (int i = 0; i < 4; i++) begin
            send(W'($urandom_range(0, 255)), 1'b0);
            recv(0, 1'b0);
        end

`ifdef RWB_PARITY_EN
        // Parity step: clean loopback, then a corrupted parity response
        mode = 0;
        send(8'h07, 1'b0);
        recv(0, 1'b0);
        send(8'h07, 1'b1);
        recv(0, 1'b0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rewire_stream_bridge.md
Name: rewire_stream_bridge

Overview:
- Host-side companion to our generated single-bit stream devices (clk/rst, one input bit and one output bit per step).
- Accepts parallel words over a valid/ready handshake, serialises each word LSB-first onto the device input bit, and deserialises the device output bit back into a word.
- Presents the result on a second valid/ready handshake.
- Gates device stepping so a device never advances while the host is stalled.

Parameters:
W, 8, word width in bits (1..32)
CNT_W, $clog2(W+1), width of the bit counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  host word available
in_ready  output  1  bridge can accept a word
in_data  input  W  host word
out_valid  output  1  result word available
out_ready  input  1  host consumes result
out_data  output  W  result word
dev_step  output  1  device clock enable; device advances one step on each clk edge where it is 1
dev_in0  output  1  serial bit to the device input
dev_out0  input  1  serial bit from the device output, Mealy: valid in the same cycle as dev_in0
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous, active-high.
  - State = IDLE; counter = 0; shift registers = 0.
  - in_ready=1, out_valid=0, out_data=0, dev_step=0, dev_in0=0, busy=0.
- IDLE:
  - in_ready=1.
  - in_valid & in_ready at an edge: load in_data into tx_sh, clear rx_sh and counter, go to SHIFT.
- SHIFT (exactly W cycles):
  - dev_step=1; dev_in0=tx_sh[0].
  - Each edge: rx_sh <= {dev_out0, rx_sh[W-1:1]}; tx_sh >>= 1; counter++.
  - When counter==W-1 at the edge: go to HOLD.
  - Bit k of in_data is presented in the k-th SHIFT cycle. The matching dev_out0 lands in out_data[k].
- HOLD:
  - out_valid=1; out_data=rx_sh stays stable; dev_step=0; dev_in0=0.
  - out_valid & out_ready at an edge: go to IDLE.
- Latency:
  - Accept edge to first SHIFT cycle: 1 cycle.
  - Accept to out_valid: W+1 cycles.
  - Minimum throughput: one word per W+2 cycles.
- in_ready is 0 in SHIFT and HOLD. in_valid is ignored there; no skid buffer.
- out_ready asserted outside HOLD has no effect.
- Backpressure in HOLD holds indefinitely. The device does not step, so device state is frozen.
- W=1: SHIFT lasts 1 cycle; the counter compare still holds.
- Reset mid-SHIFT:
  - The word is discarded; outputs return to reset values immediately (asynchronous).
  - The device receives rst from the same net and resets together with the bridge.
- dev_out0 is sampled only on edges where dev_step=1.

Optional Feature:
- Macro RWB_PARITY_EN.
- Defined:
  - SHIFT lasts W+1 cycles. The final cycle drives dev_in0 = even parity (XOR) of in_data and samples dev_out0 into a parity flop.
  - Extra output out_par_err (1 bit), valid with out_valid. It is 1 iff the sampled bit differs from the XOR of rx_sh.
  - Reset value 0.
  - Latency becomes W+2.
- Undefined: no parity step, no out_par_err port, timing exactly as above.

Decomposition:
- Package rewire_bridge_pkg:
  - typedef enum logic [1:0] {IDLE=0, SHIFT=1, HOLD=2} rwb_state_t;
  - localparam RWB_DEFAULT_W = 8.
- One natural sub-module: rewire_bridge_shreg.
  - Parameterised W-bit shift register with load, shift-enable, serial-in at MSB and serial-out at LSB.
  - Instantiated twice (tx and rx).
  - The counter and FSM stay in the top.

Test Plan (W=8, bench device model noted per line):
- Loopback (dev_out0=dev_in0): send 8'hA5 -> dev_in0 sequence 1,0,1,0,0,1,0,1; dev_step high exactly 8 cycles; out_data=8'hA5, out_valid 9 cycles after accept.
- Inverter device: send 8'h0F -> out_data=8'hF0. Then send 8'h00 -> 8'hFF. in_ready low throughout SHIFT/HOLD.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data stable, dev_step=0 for all 20 cycles; in_valid pulsed during the stall is not accepted (in_ready=0).
- Reset mid-SHIFT: assert rst after the 3rd SHIFT cycle -> same cycle in_ready=1, dev_step=0, out_valid=0. Next word 8'h3C (loopback) -> 8'h3C.
- Toggle-state device (reference stateful model, state reset to 2'b11): stream 4 words back-to-back; compare against the model for all 32 steps; no step lost or duplicated across HOLD/IDLE.
- RWB_PARITY_EN: loopback 8'h07 -> 9th step drives 1, out_par_err=0. Bench forces dev_out0=0 on the parity step -> out_par_err=1.
